frame_pixel_pacer: RTL and testbench
====================================

# frame_pixel_pacer

Single-clock pacing buffer between the camera capture path and the image-processing/VGA display stage. Accepts 8-bit grayscale pixels tagged with a start-of-frame flag, buffers them in a FIFO, and releases exactly one pixel per raster pixel request inside the 512×480 display window. Frames stay aligned to the raster: streaming starts only on a raster frame-start pulse, with a frame-start-tagged pixel at the FIFO head. Output feeds the image processor's `i_data_valid`/`i_data` inputs.

## Interface
- `DEPTH`, 1024: FIFO entries; power of two, ≥ `FILL_LEVEL`+1.
- `FILL_LEVEL`, 512: minimum occupancy before a frame may start.
- `PIX_PER_LINE`, 512: pixels per displayed line.
- `LINES`, 480: displayed lines per frame.
- `axi_clk` in 1: pixel clock, 25 MHz.
- `axi_reset_n` in 1: asynchronous, active-low reset.
- `s_valid` in 1: input pixel valid.
- `s_data` in 8: input pixel.
- `s_sof` in 1: first pixel of a frame; qualified by `s_valid`.
- `s_ready` out 1: FIFO can accept a pixel this cycle.
- `i_frame_start` in 1: one-cycle pulse from the raster, before the first window pixel of a frame.
- `i_pix_req` in 1: one-cycle pulse per display-window pixel.
- `o_data_valid` out 1: output pixel valid.
- `o_data` out 8: output pixel.
- `o_streaming` out 1: high while in STREAM.
- `o_underrun` out 1: sticky; set when a request finds the FIFO empty.

## Operation
- FIFO entries are 9 bits: {sof, data}. Push when `s_valid && s_ready`.
- `s_ready` = !full. It is low only when full; input is never dropped silently.
- States: SYNC (reset state), FILL, STREAM.
- SYNC: every head entry without sof is popped and discarded. Go to FILL when the head has sof set.
- FILL: wait until count ≥ `FILL_LEVEL` and `i_frame_start` arrives. Then go to STREAM. `i_pix_req` is ignored and produces no output.
- If `i_frame_start` arrives before the fill level is met, the frame is skipped and FILL waits for the next pulse.
- STREAM: each `i_pix_req` pops one entry and outputs its data. A mid-frame sof flag is passed through and ignored.
- Frame end: after `PIX_PER_LINE*LINES` requests (18-bit counter, wraps to 0), go to SYNC.
- Underrun: `i_pix_req` in STREAM with an empty FIFO outputs `o_data_valid`=1 with `o_data`=0x00, sets `o_underrun`, and advances the request counter.
- `i_frame_start` during STREAM is ignored. The frame always completes by count.
- Simultaneous push and pop with the FIFO not full: both happen and the count is unchanged. A push into a full FIFO is impossible because `s_ready` is low.
- Count is the pointer difference, with width log2(`DEPTH`)+1.

## Timing
- Reset values: `s_ready`=1, `o_data_valid`=0, `o_data`=0x00, `o_streaming`=0, `o_underrun`=0. Pointers, count and request counter are 0; state is SYNC.
- Reset asserted mid-frame returns to these values immediately, regardless of state.
- `o_data_valid`/`o_data` are registered: 1-cycle latency from `i_pix_req`. `o_data_valid` is a single-cycle pulse per request.
- A pushed pixel is visible at the head 1 cycle after the push; count updates on the same edge.
- SYNC discard: one entry per cycle.
- `o_streaming` rises on the edge after the accepting `i_frame_start`. It falls on the edge after the last request's output.

## Configuration
- `PACER_STATS_EN` defined: adds outputs `o_frame_cnt[15:0]` and `o_underrun_cnt[15:0]`.
  - `o_frame_cnt` increments on each completed frame.
  - `o_underrun_cnt` increments on each underrun request.
  - Both saturate at 0xFFFF, reset to 0, and are registered.
- Not defined: the ports and counters are absent. All other behaviour is identical.

## Structure
- Shared package `pacer_pkg`: state enum (SYNC, FILL, STREAM), `FRAME_PIXELS` = `PIX_PER_LINE*LINES`, request counter width 18, entry width 9.
- Sub-module `pacer_sync_fifo`: 9-bit wide, `DEPTH`-deep single-clock FIFO with count, full and empty.
- Top level holds the FSM, the request counter and the output register.

## Test plan
- Reset then idle: all outputs at reset values; state SYNC; `s_ready`=1.
- Push 3 non-sof pixels, then sof pixel 0x11 and 600 more; pulse `i_frame_start`: the 3 pixels are discarded, and the first `i_pix_req` yields 0x11 one cycle later with `o_streaming`=1.
- `i_frame_start` with count 100: no stream starts. Fill to 512 and pulse again: streaming starts.
- Full frame of 245760 requests with a continuous feed: exactly 245760 `o_data_valid` pulses, then return to SYNC, `o_underrun`=0, and `o_frame_cnt`=1 under `PACER_STATS_EN`.
- Stop input mid-frame until empty, then issue 5 requests: five outputs of 0x00, `o_underrun`=1, `o_underrun_cnt`=5.
- Fill to 1024: `s_ready`=0. Issue one request with `s_valid` held: `s_ready` returns to 1, the next push is accepted, and count returns to 1024.

Source files
------------

// File: rtl/pacer_pkg.sv
// Shared types and constants for the frame pixel pacer: state encoding,
// FIFO entry layout, request-counter width and the saturating stats helper.
package pacer_pkg;

  typedef enum logic [1:0] {SYNC = 2'd0, FILL = 2'd1, STREAM = 2'd2} pacer_state_e;

  localparam int ENTRY_W          = 9;
  localparam int REQ_W            = 18;
  localparam int PIX_PER_LINE_DEF = 512;
  localparam int LINES_DEF        = 480;
  localparam int FRAME_PIXELS     = PIX_PER_LINE_DEF * LINES_DEF;

  typedef struct packed {
    logic       sof;
    logic [7:0] data;
  } pix_entry_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/pacer_sync_fifo.sv
// Single-clock FIFO of {sof, data} entries; head is read combinationally so a
// pushed entry is visible at the head one cycle after the push.
module pacer_sync_fifo import pacer_pkg::*; #(
  parameter  int DEPTH = 1024,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          axi_clk,
  input  logic          axi_reset_n,
  input  logic          push,
  input  pix_entry_t    wr_entry,
  input  logic          pop,
  output pix_entry_t    head,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  pix_entry_t  mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge axi_clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_entry;
  end

  // Extra pointer bit makes the difference distinguish full from empty.
  assign count = wr_ptr - rd_ptr;
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/frame_pixel_pacer.sv
// Raster-aligned pixel pacer: FIFO plus SYNC/FILL/STREAM FSM releasing one pixel
// per display request. Define PACER_STATS_EN to add frame/underrun counters.
module frame_pixel_pacer import pacer_pkg::*; #(
  parameter int DEPTH        = 1024,
  parameter int FILL_LEVEL   = 512,
  parameter int PIX_PER_LINE = PIX_PER_LINE_DEF,
  parameter int LINES        = LINES_DEF
) (
  input  logic        axi_clk,
  input  logic        axi_reset_n,
  input  logic        s_valid,
  input  logic [7:0]  s_data,
  input  logic        s_sof,
  output logic        s_ready,
  input  logic        i_frame_start,
  input  logic        i_pix_req,
  output logic        o_data_valid,
  output logic [7:0]  o_data,
  output logic        o_streaming,
  output logic        o_underrun
`ifdef PACER_STATS_EN
  ,
  output logic [15:0] o_frame_cnt,
  output logic [15:0] o_underrun_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0]       S_SYNC   = 2'(SYNC);
  localparam logic [1:0]       S_FILL   = 2'(FILL);
  localparam logic [1:0]       S_STREAM = 2'(STREAM);
  localparam logic [AW:0]      FILL_C   = (AW+1)'(FILL_LEVEL);
  localparam logic [REQ_W-1:0] LAST_REQ = REQ_W'(PIX_PER_LINE * LINES - 1);

  logic [1:0]       state;
  logic [REQ_W-1:0] req_cnt;
  pix_entry_t       head, wr_entry;
  logic [AW:0]      count;
  logic             full, empty, push, pop;
  logic             req_hit, frame_done, underrun_hit;

  assign s_ready      = !full;
  assign push         = s_valid && s_ready;
  assign wr_entry     = '{sof: s_sof, data: s_data};
  assign req_hit      = (state == S_STREAM) && i_pix_req;
  assign frame_done   = req_hit && (req_cnt == LAST_REQ);
  assign underrun_hit = req_hit && empty;
  // SYNC drops stale pixels until a frame start reaches the head.
  assign pop          = ((state == S_SYNC) && !empty && !head.sof) || (req_hit && !empty);
  assign o_streaming  = (state == S_STREAM);

  pacer_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
    .axi_clk     (axi_clk),
    .axi_reset_n (axi_reset_n),
    .push        (push),
    .wr_entry    (wr_entry),
    .pop         (pop),
    .head        (head),
    .count       (count),
    .full        (full),
    .empty       (empty)
  );

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      state        <= S_SYNC;
      req_cnt      <= '0;
      o_data_valid <= 1'b0;
      o_data       <= 8'h00;
      o_underrun   <= 1'b0;
    end else begin
      o_data_valid <= 1'b0;
      case (state)
        S_SYNC:   if (!empty && head.sof) state <= S_FILL;
        S_FILL:   if (i_frame_start && (count >= FILL_C)) begin
                    state   <= S_STREAM;
                    req_cnt <= '0;
                  end
        S_STREAM: if (i_pix_req) begin
                    o_data_valid <= 1'b1;
                    o_data       <= empty ? 8'h00 : head.data;
                    if (empty) o_underrun <= 1'b1;
                    if (frame_done) begin
                      req_cnt <= '0;
                      state   <= S_SYNC;
                    end else begin
                      req_cnt <= req_cnt + 1'b1;
                    end
                  end
        default:  state <= S_SYNC;
      endcase
    end
  end

`ifdef PACER_STATS_EN
  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      o_frame_cnt    <= 16'h0000;
      o_underrun_cnt <= 16'h0000;
    end else begin
      if (frame_done)   o_frame_cnt    <= sat_inc16(o_frame_cnt);
      if (underrun_hit) o_underrun_cnt <= sat_inc16(o_underrun_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_frame_pixel_pacer.sv
// Directed bench for frame_pixel_pacer on a reduced geometry (16-deep FIFO,
// fill level 8, 4x4 frame) so every frame completes in a few dozen cycles.
module tb_frame_pixel_pacer;

  logic       axi_clk = 1'b0;
  logic       axi_reset_n;
  logic       s_valid, s_sof, s_ready;
  logic [7:0] s_data;
  logic       i_frame_start, i_pix_req;
  logic       o_data_valid, o_streaming, o_underrun;
  logic [7:0] o_data;
`ifdef PACER_STATS_EN
  logic [15:0] o_frame_cnt, o_underrun_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int pulses;

  always #5 axi_clk = ~axi_clk;

  frame_pixel_pacer #(.DEPTH(16), .FILL_LEVEL(8), .PIX_PER_LINE(4), .LINES(4)) dut (
    .axi_clk        (axi_clk),
    .axi_reset_n    (axi_reset_n),
    .s_valid        (s_valid),
    .s_data         (s_data),
    .s_sof          (s_sof),
    .s_ready        (s_ready),
    .i_frame_start  (i_frame_start),
    .i_pix_req      (i_pix_req),
    .o_data_valid   (o_data_valid),
    .o_data         (o_data),
    .o_streaming    (o_streaming),
    .o_underrun     (o_underrun)
`ifdef PACER_STATS_EN
    ,
    .o_frame_cnt    (o_frame_cnt),
    .o_underrun_cnt (o_underrun_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge axi_clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    axi_reset_n = 1'b0; s_valid = 1'b0; s_sof = 1'b0; s_data = 8'h00;
    i_frame_start = 1'b0; i_pix_req = 1'b0;
    repeat (3) @(posedge axi_clk);
    #1;
    chk("rst_s_ready",   32'(s_ready),      32'd1);
    chk("rst_valid",     32'(o_data_valid), 32'd0);
    chk("rst_data",      32'(o_data),       32'h00);
    chk("rst_streaming", 32'(o_streaming),  32'd0);
    chk("rst_underrun",  32'(o_underrun),   32'd0);
`ifdef PACER_STATS_EN
    chk("rst_frame_cnt", 32'(o_frame_cnt),    32'd0);
    chk("rst_urun_cnt",  32'(o_underrun_cnt), 32'd0);
`endif
    axi_reset_n = 1'b1;
    cyc();

    // Three stale pixels, then a frame starting at 0x11 followed by 0x12..0x1C.
    s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin s_data = 8'hA1 + 8'(i); cyc(); end
    s_sof = 1'b1; s_data = 8'h11; cyc(); s_sof = 1'b0;
    for (int i = 0; i < 11; i++) begin s_data = 8'h12 + 8'(i); cyc(); end
    s_valid = 1'b0;
    cyc(); cyc();
    chk("fill_idle_streaming", 32'(o_streaming), 32'd0);
    i_pix_req = 1'b1; cyc(); i_pix_req = 1'b0;
    chk("fill_req_ignored", 32'(o_data_valid), 32'd0);
    i_frame_start = 1'b1; cyc(); i_frame_start = 1'b0;
    chk("frame1_streaming", 32'(o_streaming), 32'd1);

    // Full frame with a continuous feed; stale pixels must not appear.
    pulses = 0;
    s_valid = 1'b1;
    for (int k = 0; k < 16; k++) begin
      s_data = 8'h1D + 8'(k); i_pix_req = 1'b1;
      cyc();
      if (o_data_valid) pulses++;
      chk($sformatf("frame1_data%0d", k), 32'(o_data), 32'h11 + 32'(k));
    end
    s_valid = 1'b0; i_pix_req = 1'b0;
    cyc();
    if (o_data_valid) pulses++;
    chk("frame1_pulses",   32'(pulses),      32'd16);
    chk("frame1_end_sync", 32'(o_streaming), 32'd0);
    chk("frame1_underrun", 32'(o_underrun),  32'd0);
`ifdef PACER_STATS_EN
    chk("frame1_cnt", 32'(o_frame_cnt), 32'd1);
`endif
    repeat (20) cyc();

    // Early frame start with only 4 entries is skipped.
    s_valid = 1'b1; s_sof = 1'b1; s_data = 8'h40; cyc(); s_sof = 1'b0;
    for (int i = 1; i < 4; i++) begin s_data = 8'h40 + 8'(i); cyc(); end
    s_valid = 1'b0; cyc(); cyc();
    i_frame_start = 1'b1; cyc(); i_frame_start = 1'b0;
    chk("early_start_skipped", 32'(o_streaming), 32'd0);
    s_valid = 1'b1;
    for (int i = 4; i < 8; i++) begin s_data = 8'h40 + 8'(i); cyc(); end
    s_valid = 1'b0; cyc();
    i_frame_start = 1'b1; cyc(); i_frame_start = 1'b0;
    chk("frame2_streaming", 32'(o_streaming), 32'd1);
    i_pix_req = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cyc();
      chk($sformatf("frame2_data%0d", k), 32'(o_data), 32'h40 + 32'(k));
    end
    chk("pre_underrun_flag", 32'(o_underrun), 32'd0);

    // FIFO now empty: five underrun requests.
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk($sformatf("urun_valid%0d", k), 32'(o_data_valid), 32'd1);
      chk($sformatf("urun_data%0d", k),  32'(o_data),       32'h00);
    end
    chk("underrun_flag", 32'(o_underrun), 32'd1);
`ifdef PACER_STATS_EN
    chk("underrun_cnt5", 32'(o_underrun_cnt), 32'd5);
`endif
    repeat (3) cyc();
    i_pix_req = 1'b0;
    cyc();
    chk("frame2_end_sync", 32'(o_streaming), 32'd0);
`ifdef PACER_STATS_EN
    chk("frame2_cnt",    32'(o_frame_cnt),    32'd2);
    chk("underrun_cnt8", 32'(o_underrun_cnt), 32'd8);
`endif

    // Fill to DEPTH, then pop one with s_valid held.
    s_valid = 1'b1; s_sof = 1'b1; s_data = 8'h50; cyc(); s_sof = 1'b0;
    for (int i = 1; i < 16; i++) begin s_data = 8'h50 + 8'(i); cyc(); end
    chk("full_not_ready", 32'(s_ready), 32'd0);
    s_data = 8'h60;
    cyc();
    chk("full_hold_ready", 32'(s_ready), 32'd0);
    i_frame_start = 1'b1; cyc(); i_frame_start = 1'b0;
    chk("frame3_streaming", 32'(o_streaming), 32'd1);
    i_pix_req = 1'b1; cyc(); i_pix_req = 1'b0;
    chk("full_pop_ready", 32'(s_ready), 32'd1);
    chk("frame3_data0",   32'(o_data),  32'h50);
    cyc();
    chk("full_refilled", 32'(s_ready), 32'd0);
    s_valid = 1'b0;
    i_pix_req = 1'b1;
    for (int k = 1; k < 16; k++) begin
      cyc();
      chk($sformatf("frame3_data%0d", k), 32'(o_data), 32'h50 + 32'(k));
    end
    i_pix_req = 1'b0;
    cyc();
    chk("frame3_end_sync", 32'(o_streaming), 32'd0);

    // Asynchronous reset clears sticky state without a clock edge.
    #2 axi_reset_n = 1'b0;
    #1;
    chk("async_rst_underrun", 32'(o_underrun),  32'd0);
    chk("async_rst_data",     32'(o_data),      32'h00);
    chk("async_rst_ready",    32'(s_ready),     32'd1);
    chk("async_rst_stream",   32'(o_streaming), 32'd0);
`ifdef PACER_STATS_EN
    chk("async_rst_frames", 32'(o_frame_cnt), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
